serdes_channel_err_inj: RTL and testbench

//  Synthesizable channel model between eth_phy_10g serdes_tx_* and serdes_rx_* in loopback benches/FPGA.

---
 rtl/serdes_channel_err_inj.sv | 145 ++++++++++++++
 tb/tb_serdes_channel_err_inj.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_channel_err_inj.sv
`default_nettype none
// ============================================================================
// Module      : serdes_channel_err_inj
// Description : 66b serdes loopback channel model with LFSR-driven header/data
//               error injection, header burst mode and saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_channel_err_inj #(
    parameter int          DATA_WIDTH     = 64,
    parameter int          HDR_WIDTH      = 2,
    parameter logic [31:0] LFSR_SEED_HDR  = 32'hACE1_2468,
    parameter logic [31:0] LFSR_SEED_DATA = 32'h1357_BDF1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] serdes_tx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    output logic [DATA_WIDTH-1:0] serdes_rx_data,
    output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    input  logic                  cfg_enable,
    input  logic [31:0]           cfg_hdr_threshold,
    input  logic [31:0]           cfg_data_threshold,
    input  logic [7:0]            cfg_burst_len,
    input  logic                  cnt_clear,
    output logic [31:0]           blk_count,
    output logic [31:0]           hdr_err_count,
    output logic [31:0]           data_err_count,
    output logic                  burst_active
);

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    logic [31:0]           r_hdr_lfsr;
    logic [31:0]           r_data_lfsr;
    logic [0:0]            r_state;
    logic [7:0]            r_remaining;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [HDR_WIDTH-1:0]  r_rx_hdr;
    logic [31:0]           r_blk_count;
    logic [31:0]           r_hdr_err_count;
    logic [31:0]           r_data_err_count;

    logic [31:0]           w_hdr_lfsr_next;
    logic [31:0]           w_data_lfsr_next;
    logic                  w_hdr_evt;
    logic                  w_data_evt;
    logic                  w_hdr_corrupt;
    logic [0:0]            w_state_next;
    logic [7:0]            w_remaining_next;
    logic [DATA_WIDTH-1:0] w_flip_mask;

    assign w_hdr_lfsr_next  = {1'b0, r_hdr_lfsr[31:1]}  ^ (r_hdr_lfsr[0]  ? c_LFSR_TAPS : 32'h0);
    assign w_data_lfsr_next = {1'b0, r_data_lfsr[31:1]} ^ (r_data_lfsr[0] ? c_LFSR_TAPS : 32'h0);

    assign w_hdr_evt   = cfg_enable & (r_hdr_lfsr  < cfg_hdr_threshold);
    assign w_data_evt  = cfg_enable & (r_data_lfsr < cfg_data_threshold);
    assign w_flip_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << r_data_lfsr[5:0];

    // Burst length counts the triggering block, so BURST covers len-1 more blocks
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_hdr_corrupt    = 1'b0;
        if (!cfg_enable) begin
            w_state_next     = c_ST_IDLE;
            w_remaining_next = 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hdr_evt) begin
                        w_hdr_corrupt = 1'b1;
                        if (cfg_burst_len > 8'd1) begin
                            w_state_next     = c_ST_BURST;
                            w_remaining_next = cfg_burst_len - 8'd1;
                        end
                    end
                end
                c_ST_BURST: begin
                    w_hdr_corrupt = 1'b1;
                    if (r_remaining <= 8'd1) begin
                        w_state_next     = c_ST_IDLE;
                        w_remaining_next = 8'd0;
                    end else begin
                        w_remaining_next = r_remaining - 8'd1;
                    end
                end
                default: begin
                    w_state_next     = c_ST_IDLE;
                    w_remaining_next = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_lfsr  <= LFSR_SEED_HDR;
            r_data_lfsr <= LFSR_SEED_DATA;
            r_state     <= c_ST_IDLE;
            r_remaining <= 8'd0;
            r_rx_data   <= '0;
            r_rx_hdr    <= '0;
        end else begin
            r_hdr_lfsr  <= w_hdr_lfsr_next;
            r_data_lfsr <= w_data_lfsr_next;
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_rx_data   <= serdes_tx_data ^ (w_data_evt ? w_flip_mask : '0);
            r_rx_hdr    <= serdes_tx_hdr ^ (w_hdr_corrupt ? HDR_WIDTH'(1) : '0);
        end
    end

    // Counters saturate rather than wrap so long soak runs stay meaningful
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            r_blk_count      <= 32'd0;
            r_hdr_err_count  <= 32'd0;
            r_data_err_count <= 32'd0;
        end else begin
            if (r_blk_count != c_CNT_MAX) begin
                r_blk_count <= r_blk_count + 32'd1;
            end
            if (w_hdr_corrupt && (r_hdr_err_count != c_CNT_MAX)) begin
                r_hdr_err_count <= r_hdr_err_count + 32'd1;
            end
            if (w_data_evt && (r_data_err_count != c_CNT_MAX)) begin
                r_data_err_count <= r_data_err_count + 32'd1;
            end
        end
    end

    assign serdes_rx_data = r_rx_data;
    assign serdes_rx_hdr  = r_rx_hdr;
    assign blk_count      = r_blk_count;
    assign hdr_err_count  = r_hdr_err_count;
    assign data_err_count = r_data_err_count;
    assign burst_active   = (r_state == c_ST_BURST);

endmodule
`default_nettype wire

// File: tb/tb_serdes_channel_err_inj.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_channel_err_inj
// Description : Vector table, directed corner sequences and randomized
//               reference-model checking for serdes_channel_err_inj.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_channel_err_inj;

    logic        clk_tb;
    logic        rx_rst_tb;
    logic [63:0] tx_data;
    logic [1:0]  tx_hdr;
    logic [63:0] rx_data;
    logic [1:0]  rx_hdr;
    logic        cfg_enable;
    logic [31:0] cfg_hdr_threshold;
    logic [31:0] cfg_data_threshold;
    logic [7:0]  cfg_burst_len;
    logic        cnt_clear;
    logic [31:0] blk_count;
    logic [31:0] hdr_err_count;
    logic [31:0] data_err_count;
    logic        burst_active;

    int n_checks = 0;
    int n_errors = 0;

    serdes_channel_err_inj dut (
        .clk                (clk_tb),
        .rst                (rx_rst_tb),
        .serdes_tx_data     (tx_data),
        .serdes_tx_hdr      (tx_hdr),
        .serdes_rx_data     (rx_data),
        .serdes_rx_hdr      (rx_hdr),
        .cfg_enable         (cfg_enable),
        .cfg_hdr_threshold  (cfg_hdr_threshold),
        .cfg_data_threshold (cfg_data_threshold),
        .cfg_burst_len      (cfg_burst_len),
        .cnt_clear          (cnt_clear),
        .blk_count          (blk_count),
        .hdr_err_count      (hdr_err_count),
        .data_err_count     (data_err_count),
        .burst_active       (burst_active)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    typedef struct {
        bit        rst;
        bit        en;
        bit [31:0] hthr;
        bit [31:0] dthr;
        bit [7:0]  bl;
        bit        clr;
        bit [63:0] d;
        bit [1:0]  h;
        bit [63:0] e_data;
        bit [1:0]  e_hdr;
        bit [31:0] e_blk;
        bit [31:0] e_herr;
        bit [31:0] e_derr;
        bit        e_burst;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: what the channel registers should hold
    bit [31:0] m_hdr_lfsr;
    bit [31:0] m_data_lfsr;
    int        m_burst_left;
    longint    m_blk, m_herr, m_derr;
    bit [63:0] m_data;
    bit [1:0]  m_hdr;

    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    function automatic bit [31:0] lfsr_adv(input bit [31:0] v);
        int        exps[4] = '{32, 22, 2, 1};
        bit [31:0] taps = 32'h0;
        foreach (exps[i]) taps[exps[i]-1] = 1'b1;
        return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit en, input bit [31:0] ht, input bit [31:0] dt,
                         input bit [7:0] bl, input bit clr, input bit [63:0] d, input bit [1:0] h);
        rx_rst_tb          = r;
        cfg_enable         = en;
        cfg_hdr_threshold  = ht;
        cfg_data_threshold = dt;
        cfg_burst_len      = bl;
        cnt_clear          = clr;
        tx_data            = d;
        tx_hdr             = h;
    endtask

    task automatic model_reset();
        m_hdr_lfsr   = 32'hACE1_2468;
        m_data_lfsr  = 32'h1357_BDF1;
        m_burst_left = 0;
        m_blk = 0; m_herr = 0; m_derr = 0;
        m_data = 64'h0; m_hdr = 2'b00;
    endtask

    // One block through the channel, starting and ending at a falling edge
    task automatic step(input bit r, input bit en, input bit [31:0] ht, input bit [31:0] dt,
                        input bit [7:0] bl, input bit clr, input bit [63:0] d, input bit [1:0] h);
        bit hevt, devt, hcor;
        apply(r, en, ht, dt, bl, clr, d, h);
        if (r) begin
            model_reset();
        end else begin
            hevt = en && (m_hdr_lfsr < ht);
            devt = en && (m_data_lfsr < dt);
            hcor = 1'b0;
            if (!en) begin
                m_burst_left = 0;
            end else if (m_burst_left > 0) begin
                hcor = 1'b1;
                m_burst_left--;
            end else if (hevt) begin
                hcor = 1'b1;
                m_burst_left = (bl > 8'd1) ? int'(bl) - 1 : 0;
            end
            m_data = d ^ (devt ? (64'd1 << m_data_lfsr[5:0]) : 64'd0);
            m_hdr  = h ^ (hcor ? 2'b01 : 2'b00);
            if (clr) begin
                m_blk = 0; m_herr = 0; m_derr = 0;
            end else begin
                m_blk = sat_inc(m_blk);
                if (hcor) m_herr = sat_inc(m_herr);
                if (devt) m_derr = sat_inc(m_derr);
            end
            m_hdr_lfsr  = lfsr_adv(m_hdr_lfsr);
            m_data_lfsr = lfsr_adv(m_data_lfsr);
        end
        @(posedge clk_tb);
        @(negedge clk_tb);
        check("rx_data",   rx_data,               m_data);
        check("rx_hdr",    64'(rx_hdr),           64'(m_hdr));
        check("blk_count", 64'(blk_count),        m_blk);
        check("hdr_err",   64'(hdr_err_count),    m_herr);
        check("data_err",  64'(data_err_count),   m_derr);
        check("burst",     64'(burst_active),     64'(m_burst_left > 0));
    endtask

    initial begin
        int        n_cor, n_act;
        bit [31:0] ht, dt;
        bit [7:0]  bl;
        bit        en;

        apply(1'b1, 1'b0, 32'h0, 32'h0, 8'd0, 1'b0, 64'h0, 2'b00);

        //           rst en hthr          dthr          bl    clr  tx_data                tx_hdr  e_data                  e_hdr  blk  herr derr burst
        tbl.push_back('{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 0, 64'h1111_2222_3333_4444, 2'b10, 64'h0,                  2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 0, 64'h0123_4567_89AB_CDEF, 2'b01, 64'h0123_4567_89AB_CDEF, 2'b01, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 0, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 2, 0, 0, 0});
        tbl.push_back('{0, 1, 32'hFFFF_FFFF, 32'h0,         8'd0, 0, 64'hA5A5_A5A5_5A5A_5A5A, 2'b10, 64'hA5A5_A5A5_5A5A_5A5A, 2'b11, 3, 1, 0, 0});
        tbl.push_back('{0, 1, 32'hFFFF_FFFF, 32'h0,         8'd0, 0, 64'hFFFF_0000_FFFF_0000, 2'b01, 64'hFFFF_0000_FFFF_0000, 2'b00, 4, 2, 0, 0});
        tbl.push_back('{0, 1, 32'hFFFF_FFFF, 32'h0,         8'd0, 0, 64'h0,                  2'b11, 64'h0,                  2'b10, 5, 3, 0, 0});
        tbl.push_back('{0, 1, 32'hFFFF_FFFF, 32'h0,         8'd0, 1, 64'h5555_5555_5555_5555, 2'b10, 64'h5555_5555_5555_5555, 2'b11, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 32'h0,         32'h0,         8'd0, 0, 64'h7777_7777_7777_7777, 2'b10, 64'h7777_7777_7777_7777, 2'b10, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd3, 0, 64'h9999_9999_9999_9999, 2'b01, 64'h0,                  2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 32'hFFFF_FFFF, 32'h0,         8'd3, 0, 64'h0000_0000_0000_0001, 2'b01, 64'h0000_0000_0000_0001, 2'b00, 1, 1, 0, 1});
        tbl.push_back('{0, 1, 32'h0,         32'h0,         8'd3, 0, 64'h0000_0000_0000_0002, 2'b10, 64'h0000_0000_0000_0002, 2'b11, 2, 2, 0, 1});
        tbl.push_back('{0, 1, 32'h0,         32'h0,         8'd3, 0, 64'h0000_0000_0000_0003, 2'b10, 64'h0000_0000_0000_0003, 2'b11, 3, 3, 0, 0});
        tbl.push_back('{0, 1, 32'h0,         32'h0,         8'd3, 0, 64'h0000_0000_0000_0004, 2'b10, 64'h0000_0000_0000_0004, 2'b10, 4, 3, 0, 0});

        @(negedge clk_tb);
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].hthr, tbl[i].dthr, tbl[i].bl, tbl[i].clr, tbl[i].d, tbl[i].h);
            @(posedge clk_tb);
            @(negedge clk_tb);
            check($sformatf("tbl%0d_data", i),  rx_data,             tbl[i].e_data);
            check($sformatf("tbl%0d_hdr", i),   64'(rx_hdr),         64'(tbl[i].e_hdr));
            check($sformatf("tbl%0d_blk", i),   64'(blk_count),      64'(tbl[i].e_blk));
            check($sformatf("tbl%0d_herr", i),  64'(hdr_err_count),  64'(tbl[i].e_herr));
            check($sformatf("tbl%0d_derr", i),  64'(data_err_count), 64'(tbl[i].e_derr));
            check($sformatf("tbl%0d_burst", i), 64'(burst_active),   64'(tbl[i].e_burst));
        end

        // Burst of 5 from one forced event; burst_len changed mid-burst must not matter
        step(1'b1, 1'b0, 32'h0, 32'h0, 8'd0, 1'b0, 64'h0, 2'b00);
        n_cor = 0; n_act = 0;
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 8'd5, 1'b0, 64'h0, 2'b10);
        if (rx_hdr != 2'b10) n_cor++;
        for (int i = 0; i < 8; i++) begin
            if (burst_active) n_act++;
            step(1'b0, 1'b1, 32'h0, 32'h0, (i < 2) ? 8'd9 : 8'd5, 1'b0, 64'h0, 2'b10);
            if (rx_hdr != 2'b10) n_cor++;
        end
        check("burst5_corrupted", 64'(n_cor), 64'd5);
        check("burst5_active",    64'(n_act), 64'd4);

        // Data-only injection on zero data: one bit flipped per block, header untouched
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 8'd0, 1'b0, 64'h0, 2'b01);
            check("popcount1", 64'($countones(rx_data)), 64'd1);
        end

        // Reset mid-burst, then disable mid-burst
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 8'd10, 1'b0, 64'h1, 2'b01);
        step(1'b0, 1'b1, 32'h0, 32'h0, 8'd10, 1'b0, 64'h2, 2'b01);
        step(1'b1, 1'b1, 32'h0, 32'h0, 8'd10, 1'b0, 64'h3, 2'b01);
        step(1'b0, 1'b1, 32'h0, 32'h0, 8'd10, 1'b0, 64'h4, 2'b01);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 8'd10, 1'b0, 64'h5, 2'b01);
        step(1'b0, 1'b1, 32'h0, 32'h0, 8'd10, 1'b0, 64'h6, 2'b01);
        step(1'b0, 1'b0, 32'h0, 32'h0, 8'd10, 1'b0, 64'h7, 2'b01);
        step(1'b0, 1'b1, 32'h0, 32'h0, 8'd10, 1'b0, 64'h8, 2'b01);
        step(1'b0, 1'b1, 32'h0, 32'h0, 8'd10, 1'b0, 64'h9, 2'b01);

        // Counters preloaded near the top must stick at all-ones, then clear
        force dut.r_blk_count      = 32'hFFFF_FFFD;
        force dut.r_hdr_err_count  = 32'hFFFF_FFFD;
        force dut.r_data_err_count = 32'hFFFF_FFFD;
        #1;
        release dut.r_blk_count;
        release dut.r_hdr_err_count;
        release dut.r_data_err_count;
        m_blk = 64'hFFFF_FFFD; m_herr = 64'hFFFF_FFFD; m_derr = 64'hFFFF_FFFD;
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 1'b0, 64'hF0F0, 2'b10);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 1'b1, 64'hF0F0, 2'b10);

        // Randomized run against the reference model
        en = 1'b1; ht = 32'h1999_999A; dt = 32'h0; bl = 8'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                en = ($urandom_range(0, 7) != 0);
                case ($urandom_range(0, 3))
                    0: ht = 32'h0;
                    1: ht = 32'hFFFF_FFFF;
                    2: ht = 32'h1999_999A;
                    default: ht = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0: dt = 32'h0;
                    1: dt = 32'hFFFF_FFFF;
                    2: dt = 32'h1999_999A;
                    default: dt = $urandom;
                endcase
                bl = 8'($urandom_range(0, 6));
            end
            step(($urandom_range(0, 255) == 0), en, ht, dt, bl, ($urandom_range(0, 63) == 0),
                 {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
